freq_bin_reader: RTL

//  Read side of the frequency-bin BRAM. On a start pulse, sweeps bins 0..BINS-1 through
//  the BRAM read port, absorbs the 1-cycle read latency and streams {bin, magnitude} out
//  on a valid/ready interface with full backpressure. Feeds display/UART sinks.

---
 rtl/freq_defs.sv | 12 +
 rtl/freq_skid_fifo.sv | 57 +++++
 rtl/freq_bin_reader.sv | 100 ++++++++++
 3 files changed

// File: rtl/freq_defs.sv
// Shared definitions for the frequency-bin BRAM reader and writer.
package freq_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } freq_state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/freq_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs the BRAM read latency under backpressure.
module freq_skid_fifo
  import freq_defs::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = slot0;

  // slot0 is always the head, so the payload only moves on a pop or a push into empty
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Overflow means the reader's issue gate let one read too many through
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop_ok && (count == 2'(FIFO_DEPTH))));

endmodule

// File: rtl/freq_bin_reader.sv
// Sweeps the frequency-bin BRAM and streams {bin, magnitude} beats with full backpressure.
module freq_bin_reader
  import freq_defs::*;
#(
  parameter int addr_w = 7,
  parameter int data_w = 8,
  parameter int BINS   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [addr_w-1:0] r_addr,
  output logic              r_en,
  input  logic [data_w-1:0] d_out,
  output logic [data_w-1:0] o_data,
  output logic [addr_w-1:0] o_bin,
  output logic              o_last,
  output logic              o_valid,
  input  logic              o_ready
);

  localparam int W = 1 + addr_w + data_w;
  localparam logic [addr_w-1:0] LAST = addr_w'(BINS - 1);

  freq_state_t       state_q;
  freq_state_t       state_d;
  logic [addr_w-1:0] issue_cnt;
  logic [addr_w-1:0] addr_q;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic [W-1:0]      push_data;
  logic [W-1:0]      head;

  assign pop    = o_valid && o_ready;
  // Issue only when the beat it produces is guaranteed a FIFO slot on arrival
  assign occ    = {1'b0, count} + {2'b00, inflight};
  assign issue  = (state_q == SCAN) && (occ < (3'd2 + {2'b00, pop}));
  assign r_en   = issue;
  assign r_addr = issue_cnt;
  assign busy   = (state_q != IDLE);

  assign push_data = {(addr_q == LAST), addr_q, d_out};
  assign {o_last, o_bin, o_data} = head;
  assign o_valid = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (issue && (issue_cnt == LAST)) state_d = DRAIN;
      DRAIN: begin
        if (pop && o_last) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter parks on the last bin so the address never wraps within a sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt <= '0;
      addr_q    <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) addr_q <= issue_cnt;
      if (state_q == IDLE && start)
        issue_cnt <= '0;
      else if (issue && (issue_cnt != LAST))
        issue_cnt <= issue_cnt + 1'b1;
    end
  end

  freq_skid_fifo #(
    .W(W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

endmodule
